// File: rtl/ustc_xbar_dispatch.sv
// Line-vector dispatcher for the N x N crossbar: 2-entry input FIFO, one-hot
// switch-control decode, credit-gated issue and a valid pipe matching the crossbar latency.
module ustc_xbar_dispatch #(
    parameter int N            = 8,
    parameter int DW_DATA      = 32,
    parameter int NUM_PER_LINE = 4,
    parameter int DW_LINE      = DW_DATA * NUM_PER_LINE,
    parameter int SEL_W        = $clog2(N),
    parameter int XBAR_LAT     = 1,
    parameter int CREDITS      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [N*DW_LINE-1:0]   s_data,
    input  logic [N*SEL_W-1:0]     s_sel,
    input  logic [N-1:0]           s_en,
    output logic [N*N-1:0]         xbar_ctrl,
    output logic [N*DW_LINE-1:0]   xbar_in,
    output logic                   xbar_issue,
    output logic                   out_valid,
    input  logic                   credit_ret,
    output logic [3:0]             credit_cnt,
    output logic [31:0]            issue_cnt
);

    localparam logic [3:0] CREDITS_MAX = 4'(CREDITS);

    // Column j selects source row s_sel[j]; out-of-range sources simply match no row.
    function automatic logic [N*N-1:0] decode_ctrl(input logic [N*SEL_W-1:0] sel,
                                                   input logic [N-1:0]       en);
        logic [N*N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (en[j] && (int'(sel[j*SEL_W +: SEL_W]) == i)) begin
                    m[i*N+j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    logic [N*DW_LINE-1:0] fifo_data_q [2];
    logic [N*DW_LINE-1:0] fifo_data_d [2];
    logic [N*SEL_W-1:0]   fifo_sel_q  [2];
    logic [N*SEL_W-1:0]   fifo_sel_d  [2];
    logic [N-1:0]         fifo_en_q   [2];
    logic [N-1:0]         fifo_en_d   [2];

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic [3:0] credit_q, credit_d;
    logic [31:0] issue_cnt_q, issue_cnt_d;

    logic                 xbar_issue_q, xbar_issue_d;
    logic [N*N-1:0]       xbar_ctrl_q, xbar_ctrl_d;
    logic [N*DW_LINE-1:0] xbar_in_q, xbar_in_d;

    logic push;
    logic pop;
    logic ret_acc;

    // Readiness comes from the registered count only, so a pop never frees a
    // slot for a push in the same cycle; it is also held low while in reset.
    assign s_ready = reset && (count_q != 2'd2);
    assign push    = s_valid && s_ready;
    assign pop     = (count_q != 2'd0) && (credit_q != 4'd0);
    assign ret_acc = credit_ret && (credit_q != CREDITS_MAX);

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_sel_d  = fifo_sel_q;
        fifo_en_d   = fifo_en_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = s_data;
            fifo_sel_d[wr_ptr_q]  = s_sel;
            fifo_en_d[wr_ptr_q]   = s_en;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;
        count_d      = count_q + 2'(push) - 2'(pop);
        credit_d     = credit_q + 4'(ret_acc) - 4'(pop);
        issue_cnt_d  = issue_cnt_q + 32'(pop);
        xbar_issue_d = pop;
        xbar_ctrl_d  = '0;
        xbar_in_d    = xbar_in_q;
        if (pop) begin
            xbar_ctrl_d = decode_ctrl(fifo_sel_q[rd_ptr_q], fifo_en_q[rd_ptr_q]);
            xbar_in_d   = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_sel_q  <= fifo_sel_d;
        fifo_en_q   <= fifo_en_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            credit_q     <= CREDITS_MAX;
            issue_cnt_q  <= 32'd0;
            xbar_issue_q <= 1'b0;
            xbar_ctrl_q  <= '0;
            xbar_in_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            credit_q     <= credit_d;
            issue_cnt_q  <= issue_cnt_d;
            xbar_issue_q <= xbar_issue_d;
            xbar_ctrl_q  <= xbar_ctrl_d;
            xbar_in_q    <= xbar_in_d;
        end
    end

    generate
        if (XBAR_LAT == 0) begin : g_no_lat
            assign out_valid = xbar_issue_q;
        end else begin : g_lat
            logic [XBAR_LAT-1:0] lat_q, lat_d;

            always_comb begin
                lat_d    = lat_q;
                lat_d[0] = xbar_issue_q;
                for (int k = 1; k < XBAR_LAT; k++) begin
                    lat_d[k] = lat_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lat_q <= '0;
                end else begin
                    lat_q <= lat_d;
                end
            end

            assign out_valid = lat_q[XBAR_LAT-1];
        end
    endgenerate

    assign xbar_issue = xbar_issue_q;
    assign xbar_ctrl  = xbar_ctrl_q;
    assign xbar_in    = xbar_in_q;
    assign credit_cnt = credit_q;
    assign issue_cnt  = issue_cnt_q;

endmodule

// File: tb/tb_ustc_xbar_dispatch.sv
// Randomised + directed bench for ustc_xbar_dispatch with a queue-based
// reference model and a negedge monitor that scores every cycle.
module tb_ustc_xbar_dispatch;

    localparam int N        = 8;
    localparam int DW_DATA  = 32;
    localparam int NPL      = 4;
    localparam int DW_LINE  = DW_DATA * NPL;
    localparam int SEL_W    = 3;
    localparam int LAT      = 1;
    localparam int CREDITS  = 4;
    localparam int DW       = N * DW_LINE;
    localparam int NWORDS   = DW / 32;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [DW-1:0]      s_data = '0;
    logic [N*SEL_W-1:0] s_sel = '0;
    logic [N-1:0]       s_en = '0;
    logic [N*N-1:0]     xbar_ctrl;
    logic [DW-1:0]      xbar_in;
    logic               xbar_issue;
    logic               out_valid;
    logic               credit_ret = 1'b0;
    logic [3:0]         credit_cnt;
    logic [31:0]        issue_cnt;

    ustc_xbar_dispatch #(
        .N(N), .DW_DATA(DW_DATA), .NUM_PER_LINE(NPL), .DW_LINE(DW_LINE),
        .SEL_W(SEL_W), .XBAR_LAT(LAT), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sel(s_sel), .s_en(s_en), .xbar_ctrl(xbar_ctrl),
        .xbar_in(xbar_in), .xbar_issue(xbar_issue), .out_valid(out_valid),
        .credit_ret(credit_ret), .credit_cnt(credit_cnt), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0]   ctrl;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            occ = 0;
    int            cred = CREDITS;
    logic [31:0]   cnt_m = 32'd0;
    bit            acc_prev = 1'b0;
    bit            ret_prev = 1'b0;
    logic [DW-1:0] last_in = '0;
    logic [15:0]   hist = '0;
    int            issue_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            for (int w = 0; w < NWORDS; w++) begin
                if (act[w*32 +: 32] !== req[w*32 +: 32]) begin
                    $display("FAIL %s word%0d actual=%0h required=%0h t=%0t",
                             name, w, act[w*32 +: 32], req[w*32 +: 32], $time);
                    break;
                end
            end
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Column c takes its source row from sel; a disabled or out-of-range column stays empty.
    function automatic logic [63:0] ref_ctrl(input logic [N*SEL_W-1:0] sel, input logic [N-1:0] en);
        logic [63:0] m;
        m = '0;
        for (int col = 0; col < N; col++) begin
            int src;
            src = int'(sel[col*SEL_W +: SEL_W]);
            if (en[col] && src < N) m[src*N + col] = 1'b1;
        end
        return m;
    endfunction

    // Monitor / scoreboard: model state holds what the design should contain after each edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                occ = 0; cred = CREDITS; cnt_m = 32'd0;
                acc_prev = 1'b0; ret_prev = 1'b0;
                exp_q.delete(); last_in = '0; hist = '0;
            end else begin
                bit   exp_issue;
                exp_t e;
                exp_issue = (occ > 0) && (cred > 0);
                if (xbar_issue) issue_seen++;
                chk("xbar_issue", 64'(xbar_issue), 64'(exp_issue));
                if (exp_issue) begin
                    if (exp_q.size() == 0) begin
                        fail_now("scoreboard_underflow");
                    end else begin
                        e = exp_q.pop_front();
                        chk("xbar_ctrl", 64'(xbar_ctrl), e.ctrl);
                        chk_data("xbar_in", xbar_in, e.data);
                        last_in = e.data;
                    end
                end else begin
                    chk("xbar_ctrl_idle", 64'(xbar_ctrl), 64'd0);
                    chk_data("xbar_in_hold", xbar_in, last_in);
                end
                hist = {hist[14:0], exp_issue};
                chk("out_valid", 64'(out_valid), 64'((LAT == 0) ? exp_issue : hist[LAT]));
                if (ret_prev && cred < CREDITS) cred++;
                if (exp_issue) cred--;
                occ = occ + int'(acc_prev) - int'(exp_issue);
                if (exp_issue) cnt_m = cnt_m + 32'd1;
                chk("credit_cnt", 64'(credit_cnt), 64'(cred));
                chk("issue_cnt", 64'(issue_cnt), 64'(cnt_m));
                chk("s_ready", 64'(s_ready), 64'(occ < 2));
                acc_prev = s_valid && (occ < 2);
                if (acc_prev) begin
                    e.ctrl = ref_ctrl(s_sel, s_en);
                    e.data = s_data;
                    exp_q.push_back(e);
                end
                ret_prev = credit_ret;
            end
        end
    end

    task automatic rand_line(output logic [DW-1:0] d);
        for (int w = 0; w < NWORDS; w++) d[w*32 +: 32] = $urandom;
    endtask

    // Presents one line and waits (bounded) for the handshake; entered and left at posedge+1.
    task automatic send(input logic [DW-1:0] d, input logic [N*SEL_W-1:0] sel,
                        input logic [N-1:0] en, input int budget, output bit ok);
        s_valid = 1'b1; s_data = d; s_sel = sel; s_en = en;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic give_credits(input int n);
        for (int k = 0; k < n; k++) begin
            credit_ret = 1'b1;
            @(posedge clk); #1;
        end
        credit_ret = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            credit_ret = (credit_cnt < 4'(CREDITS));
            @(posedge clk); #1;
        end
        credit_ret = 1'b0;
    endtask

    task automatic wait_issue(input string name, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (xbar_issue) seen = 1'b1;
        end
        if (!seen) fail_now({name, "_timeout"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0]      d;
        logic [N*SEL_W-1:0] sel;
        bit                 ok;
        bit                 seen;
        int                 base;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_xbar_ctrl", 64'(xbar_ctrl), 64'd0);
        chk_data("rst_xbar_in", xbar_in, '0);
        chk("rst_xbar_issue", 64'(xbar_issue), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_credit_cnt", 64'(credit_cnt), 64'd4);
        chk("rst_issue_cnt", 64'(issue_cnt), 64'd0);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;

        // Identity route
        d = '0;
        for (int i = 0; i < N; i++) d[i*DW_LINE +: DW_LINE] = DW_LINE'(i);
        for (int j = 0; j < N; j++) sel[j*SEL_W +: SEL_W] = SEL_W'(j);
        send(d, sel, 8'hFF, 8, ok);
        chk("identity_accept", 64'(ok), 64'd1);
        wait_issue("identity", seen);
        chk("identity_ctrl", 64'(xbar_ctrl), 64'h8040201008040201);
        chk_data("identity_data", xbar_in, d);
        chk("identity_ov_same_cycle", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("identity_ov_next", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        give_credits(1);

        // Multicast with disabled upper columns
        rand_line(d);
        for (int j = 0; j < N; j++) sel[j*SEL_W +: SEL_W] = 3'd3;
        send(d, sel, 8'h0F, 8, ok);
        chk("mcast_accept", 64'(ok), 64'd1);
        wait_issue("mcast", seen);
        chk("mcast_ctrl", 64'(xbar_ctrl), 64'h0000_0000_0F00_0000);
        @(posedge clk); #1;
        give_credits(1);

        // Credit return while already full is ignored
        give_credits(2);
        repeat (2) @(posedge clk);
        #1;
        chk("credit_saturate", 64'(credit_cnt), 64'd4);

        // Credit stall: six lines, four issue, two remain queued
        base = issue_seen;
        for (int k = 0; k < 6; k++) begin
            rand_line(d);
            send(d, 24'($urandom), 8'($urandom), 8, ok);
            chk("stall_accept", 64'(ok), 64'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("stall_issues", 64'(issue_seen - base), 64'd4);
        chk("stall_credit", 64'(credit_cnt), 64'd0);
        chk("stall_full_ready", 64'(s_ready), 64'd0);

        // Full FIFO: a seventh line waits, and the pop edge does not accept it
        rand_line(d);
        s_valid = 1'b1; s_data = d; s_sel = 24'($urandom); s_en = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        credit_ret = 1'b1;
        @(negedge clk);
        chk("full_no_accept_on_pop", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        credit_ret = 1'b0;
        send(d, s_sel, s_en, 3, ok);
        chk("full_accept_after_pop", 64'(ok), 64'd1);

        // Returns coinciding with issues leave the count unchanged
        give_credits(3);
        chk("simul_ret_issue", 64'(credit_cnt), 64'd1);
        drain();

        // Asynchronous reset with two lines queued
        for (int k = 0; k < 6; k++) begin
            rand_line(d);
            send(d, 24'($urandom), 8'($urandom), 8, ok);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("arst_s_ready", 64'(s_ready), 64'd0);
        chk("arst_xbar_ctrl", 64'(xbar_ctrl), 64'd0);
        chk_data("arst_xbar_in", xbar_in, '0);
        chk("arst_xbar_issue", 64'(xbar_issue), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_credit_cnt", 64'(credit_cnt), 64'd4);
        chk("arst_issue_cnt", 64'(issue_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk); #1;
        base = issue_seen;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_no_issue_after", 64'(issue_seen - base), 64'd0);

        // issue_cnt wrap
        #1;
        force dut.issue_cnt_q = 32'hFFFF_FFFE;
        cnt_m = 32'hFFFF_FFFE;
        #1;
        release dut.issue_cnt_q;
        for (int k = 0; k < 2; k++) begin
            rand_line(d);
            send(d, 24'($urandom), 8'($urandom), 8, ok);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("issue_cnt_wrap", 64'(issue_cnt), 64'd0);
        drain();

        // Randomised traffic with periods of withheld credits
        for (int i = 0; i < 800; i++) begin
            s_valid = ($urandom % 4) != 0;
            rand_line(d);
            s_data = d;
            s_sel = 24'($urandom);
            s_en = 8'($urandom);
            if (((i / 50) % 3) == 2) credit_ret = 1'b0;
            else credit_ret = (credit_cnt < 4'(CREDITS)) && (($urandom % 3) != 0);
            @(posedge clk); #1;
        end
        drain();
        chk("end_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("end_credit_cnt", 64'(credit_cnt), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
